// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci series generator and its checker.
package fib_pkg;

   localparam int FIB_WIDTH = 32;
   localparam int FIB_CNT_W = 16;

   localparam int FIB_SEED0 = 0;
   localparam int FIB_SEED1 = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEED1 = 3'd1,
      ST_CHECK = 3'd2,
      ST_ERR   = 3'd3,
      ST_OVF   = 3'd4
   } fib_chk_state_e;

endpackage

// File: rtl/fib_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt
   import fib_pkg::*;
#(
   parameter int W = FIB_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/fib_checker.sv
// Streaming recurrence checker for the Fibonacci generator output.
// Optional macro FIB_CHECK_SEED_EN additionally enforces seeds 0 and 1.
module fib_checker
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH,
   parameter int CNT_W = FIB_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic [CNT_W-1:0] term_cnt,
   output logic             seq_ok,
   output logic             err,
   output logic [CNT_W-1:0] err_idx,
   output logic [WIDTH-1:0] err_exp,
   output logic             ovf
);

   fib_chk_state_e   state_q, state_d;
   logic [WIDTH-1:0] prev1_q, prev1_d;
   logic [WIDTH-1:0] prev2_q, prev2_d;
   logic             err_q, err_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] err_idx_q, err_idx_d;
   logic [WIDTH-1:0] err_exp_q, err_exp_d;
   logic [WIDTH:0]   expected;
   logic             seed0_bad;
   logic             seed1_bad;

   sat_cnt #(.W(CNT_W)) u_term_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (in_valid),
      .cnt   (term_cnt)
   );

   // Carry bit of the extra-wide sum marks the series leaving the data width.
   assign expected = {1'b0, prev1_q} + {1'b0, prev2_q};

`ifdef FIB_CHECK_SEED_EN
   assign seed0_bad = (in_data != WIDTH'(FIB_SEED0));
   assign seed1_bad = (in_data != WIDTH'(FIB_SEED1));
`else
   assign seed0_bad = 1'b0;
   assign seed1_bad = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      prev1_d   = prev1_q;
      prev2_d   = prev2_q;
      err_d     = err_q;
      ovf_d     = ovf_q;
      err_idx_d = err_idx_q;
      err_exp_d = err_exp_q;
      if (clear) begin
         state_d   = ST_IDLE;
         prev1_d   = '0;
         prev2_d   = '0;
         err_d     = 1'b0;
         ovf_d     = 1'b0;
         err_idx_d = '0;
         err_exp_d = '0;
      end else if (in_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (seed0_bad) begin
                  err_d     = 1'b1;
                  err_idx_d = '0;
                  err_exp_d = WIDTH'(FIB_SEED0);
                  state_d   = ST_ERR;
               end else begin
                  prev2_d = in_data;
                  state_d = ST_SEED1;
               end
            end
            ST_SEED1: begin
               if (seed1_bad) begin
                  err_d     = 1'b1;
                  err_idx_d = CNT_W'(1);
                  err_exp_d = WIDTH'(FIB_SEED1);
                  state_d   = ST_ERR;
               end else begin
                  prev1_d = in_data;
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (expected[WIDTH]) begin
                  ovf_d   = 1'b1;
                  state_d = ST_OVF;
               end else if (in_data != expected[WIDTH-1:0]) begin
                  err_d     = 1'b1;
                  err_idx_d = term_cnt;
                  err_exp_d = expected[WIDTH-1:0];
                  state_d   = ST_ERR;
               end else begin
                  prev2_d = prev1_q;
                  prev1_d = in_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         prev1_q   <= '0;
         prev2_q   <= '0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         err_idx_q <= '0;
         err_exp_q <= '0;
      end else begin
         state_q   <= state_d;
         prev1_q   <= prev1_d;
         prev2_q   <= prev2_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
         err_idx_q <= err_idx_d;
         err_exp_q <= err_exp_d;
      end
   end

   assign seq_ok  = !err_q;
   assign err     = err_q;
   assign ovf     = ovf_q;
   assign err_idx = err_idx_q;
   assign err_exp = err_exp_q;

endmodule
